// File: rtl/add_limb_chain_pkg.sv
// add_limb_chain_pkg: shared state encoding, default sizes and counter-width helper
// Revision 1.0
`default_nettype none

package add_limb_chain_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  localparam int DEF_W         = 8;
  localparam int DEF_MAX_LIMBS = 16;

  // Limb counter must be at least one bit even for single-limb operands
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/add_pg_core.sv
// add_pg_core: W-bit Kogge-Stone style parallel-prefix adder with carry-in and carry-out
// Revision 1.0
`default_nettype none

module add_pg_core
  import add_limb_chain_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  localparam int LV = (W > 1) ? $clog2(W) : 1;

  logic [W-1:0] p0;
  logic [W-1:0] g_cur;
  logic [W-1:0] p_cur;
  logic [W-1:0] g_nxt;
  logic [W-1:0] p_nxt;

  always_comb begin
    p0    = a ^ b;
    g_cur = a & b;
    // Fold carry-in into bit 0 so every prefix G[i:0] is a true carry
    g_cur[0] = (a[0] & b[0]) | (p0[0] & cin);
    p_cur = p0;
    g_nxt = '0;
    p_nxt = '0;
    for (int l = 0; l < LV; l++) begin
      g_nxt = g_cur;
      p_nxt = p_cur;
      for (int i = (1 << l); i < W; i++) begin
        g_nxt[i] = g_cur[i] | (p_cur[i] & g_cur[i - (1 << l)]);
        p_nxt[i] = p_cur[i] & p_cur[i - (1 << l)];
      end
      g_cur = g_nxt;
      p_cur = p_nxt;
    end
  end

  assign sum  = p0 ^ {g_cur[W-2:0], cin};
  assign cout = g_cur[W-1];

endmodule

`default_nettype wire

// File: rtl/add_limb_chain.sv
// add_limb_chain: streaming LSB-first multi-limb adder with carry chained across handshakes
// Revision 1.0
`default_nettype none

module add_limb_chain
  import add_limb_chain_pkg::*;
#(
  parameter int W         = DEF_W,
  parameter int MAX_LIMBS = DEF_MAX_LIMBS
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_sum,
  output logic         out_last,
  output logic         out_carry,
  output logic         out_err
);

  localparam int            CW       = cnt_width(MAX_LIMBS);
  localparam logic [CW-1:0] LAST_IDX = CW'(MAX_LIMBS - 1);

  state_t        state;
  logic          carry_q;
  logic [CW-1:0] limb_cnt;

  logic          accept;
  logic          eff_last;
  logic          carry_in;
  logic [W-1:0]  sum;
  logic          cout;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign carry_in = (state == ST_BUSY) ? carry_q : 1'b0;
  // Operands that never raise in_last are cut at the last counter slot
  assign eff_last = in_last || (limb_cnt == LAST_IDX);

  add_pg_core #(.W(W)) u_core (
    .a    (in_a),
    .b    (in_b),
    .cin  (carry_in),
    .sum  (sum),
    .cout (cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      carry_q   <= 1'b0;
      limb_cnt  <= '0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_last  <= 1'b0;
      out_carry <= 1'b0;
      out_err   <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_sum   <= sum;
      out_last  <= eff_last;
      out_carry <= eff_last ? cout : 1'b0;
      out_err   <= eff_last && !in_last;
      carry_q   <= eff_last ? 1'b0 : cout;
      limb_cnt  <= eff_last ? '0 : limb_cnt + 1'b1;
      state     <= eff_last ? ST_IDLE : ST_BUSY;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

`default_nettype wire
